// File: rtl/lz_token_encoder.sv
// lz_token_encoder
// ----------------
// Takes one dictionary-search result per handshake and turns it into LZ
// tokens for the bit packer. Consecutive hits that share an offset are
// merged into one (offset, length) match token. A non-hit byte becomes a
// literal token. A hit run shorter than MIN_MATCH is replayed as literals
// from a small byte buffer. The token port is a single registered
// valid/ready stage, and a token becomes visible one cycle after its
// input is accepted.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational)
//   in_byte           raw symbol
//   in_hit            search reported a dictionary hit
//   in_offset         match distance of the hit
//   in_last           final symbol of the block
//   tok_valid/ready   output handshake
//   tok_is_match      1 = match token, 0 = literal
//   tok_literal       literal byte (0 for matches)
//   tok_offset        match offset (0 for literals)
//   tok_length        match length (0 for literals)
//   tok_last          final token of the block
module lz_token_encoder #(
  parameter int OFF_W     = 8,
  parameter int LEN_W     = 4,
  parameter int MIN_MATCH = 3,
  parameter int MAX_LEN   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_hit,
  input  logic [OFF_W-1:0] in_offset,
  input  logic             in_last,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic             tok_is_match,
  output logic [7:0]       tok_literal,
  output logic [OFF_W-1:0] tok_offset,
  output logic [LEN_W-1:0] tok_length,
  output logic             tok_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // The buffer only has to hold a run that is too short to become a match.
  localparam int BUF_N = MIN_MATCH - 1;
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_MATCH);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

  state_t             state_r, state_s;
  logic [OFF_W-1:0]   cand_off_r, cand_off_s;
  logic [LEN_W-1:0]   cand_len_r, cand_len_s;
  logic               cand_last_r, cand_last_s;
  logic [LEN_W-1:0]   flush_idx_r, flush_idx_s;
  logic [7:0]         buf_r [BUF_N];

  logic               out_free_s;
  logic               continue_s;
  logic [LEN_W-1:0]   nxt_len_s;
  logic               buf_we_s;
  logic [LEN_W-1:0]   buf_idx_s;
  logic [7:0]         buf_rd_s;
  logic               in_ready_s;

  logic               tok_load_s;
  logic               ld_is_match_s;
  logic [7:0]         ld_literal_s;
  logic [OFF_W-1:0]   ld_offset_s;
  logic [LEN_W-1:0]   ld_length_s;
  logic               ld_last_s;

  assign out_free_s = !tok_valid || tok_ready;
  assign nxt_len_s  = cand_len_r + ONE_LEN;
  assign continue_s = in_valid && in_hit && (in_offset == cand_off_r) &&
                      (cand_len_r < MAX_L);
  assign in_ready   = in_ready_s;

  // Select the buffered byte addressed by the flush pointer (mask-OR mux).
  always_comb begin
    buf_rd_s = 8'h00;
    for (int i = 0; i < BUF_N; i++) begin
      buf_rd_s = buf_rd_s | (buf_r[i] & {8{flush_idx_r == LEN_W'(i)}});
    end
  end

  // Next-state, candidate update, input ready and token-load decode.
  always_comb begin
    state_s       = state_r;
    cand_off_s    = cand_off_r;
    cand_len_s    = cand_len_r;
    cand_last_s   = cand_last_r;
    flush_idx_s   = flush_idx_r;
    buf_we_s      = 1'b0;
    buf_idx_s     = {LEN_W{1'b0}};
    in_ready_s    = 1'b0;
    tok_load_s    = 1'b0;
    ld_is_match_s = 1'b0;
    ld_literal_s  = 8'h00;
    ld_offset_s   = {OFF_W{1'b0}};
    ld_length_s   = {LEN_W{1'b0}};
    ld_last_s     = 1'b0;

    if (reset) begin
      // Nothing is accepted while reset is applied; the register block
      // clears the state itself.
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_s = out_free_s;
          if (in_valid && out_free_s) begin
            if (!in_hit) begin
              tok_load_s   = 1'b1;
              ld_literal_s = in_byte;
              ld_last_s    = in_last;
            end else begin
              cand_off_s  = in_offset;
              cand_len_s  = ONE_LEN;
              cand_last_s = in_last;
              flush_idx_s = {LEN_W{1'b0}};
              buf_we_s    = 1'b1;
              buf_idx_s   = {LEN_W{1'b0}};
              state_s     = in_last ? FLUSH : ACCUM;
            end
          end else begin
            state_s = IDLE;
          end
        end

        ACCUM: begin
          if (continue_s) begin
            in_ready_s = 1'b1;
            cand_len_s = nxt_len_s;
            // Bytes are only kept while the run could still end up short.
            if (cand_len_r < (MIN_LEN - ONE_LEN)) begin
              buf_we_s  = 1'b1;
              buf_idx_s = cand_len_r;
            end else begin
              buf_we_s = 1'b0;
            end
            if (in_last || (nxt_len_s == MAX_L)) begin
              cand_last_s = in_last;
              state_s     = (nxt_len_s >= MIN_LEN) ? EMIT : FLUSH;
            end else begin
              state_s = ACCUM;
            end
          end else if (in_valid) begin
            // A breaking symbol stays upstream and is taken again from IDLE.
            in_ready_s = 1'b0;
            state_s    = (cand_len_r >= MIN_LEN) ? EMIT : FLUSH;
          end else begin
            state_s = ACCUM;
          end
        end

        EMIT: begin
          if (out_free_s) begin
            tok_load_s    = 1'b1;
            ld_is_match_s = 1'b1;
            ld_offset_s   = cand_off_r;
            ld_length_s   = cand_len_r;
            ld_last_s     = cand_last_r;
            cand_off_s    = {OFF_W{1'b0}};
            cand_len_s    = {LEN_W{1'b0}};
            cand_last_s   = 1'b0;
            state_s       = IDLE;
          end else begin
            state_s = EMIT;
          end
        end

        FLUSH: begin
          if (out_free_s) begin
            tok_load_s   = 1'b1;
            ld_literal_s = buf_rd_s;
            if (flush_idx_r == (cand_len_r - ONE_LEN)) begin
              // Only the final replayed byte may carry the block end.
              ld_last_s   = cand_last_r;
              cand_off_s  = {OFF_W{1'b0}};
              cand_len_s  = {LEN_W{1'b0}};
              cand_last_s = 1'b0;
              flush_idx_s = {LEN_W{1'b0}};
              state_s     = IDLE;
            end else begin
              flush_idx_s = flush_idx_r + ONE_LEN;
              state_s     = FLUSH;
            end
          end else begin
            state_s = FLUSH;
          end
        end

        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and candidate registers; reset drops any partial run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cand_off_r  <= {OFF_W{1'b0}};
      cand_len_r  <= {LEN_W{1'b0}};
      cand_last_r <= 1'b0;
      flush_idx_r <= {LEN_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cand_off_r  <= cand_off_s;
      cand_len_r  <= cand_len_s;
      cand_last_r <= cand_last_s;
      flush_idx_r <= flush_idx_s;
    end
  end

  // Short-run byte buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_N; i++) begin
        buf_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < BUF_N; i++) begin
        if (buf_we_s && (buf_idx_s == LEN_W'(i))) begin
          buf_r[i] <= in_byte;
        end
      end
    end
  end

  // Output token register: load when free, clear after a bare transfer,
  // otherwise hold the fields stable for the packer.
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_valid    <= 1'b0;
      tok_is_match <= 1'b0;
      tok_literal  <= 8'h00;
      tok_offset   <= {OFF_W{1'b0}};
      tok_length   <= {LEN_W{1'b0}};
      tok_last     <= 1'b0;
    end else if (tok_load_s) begin
      tok_valid    <= 1'b1;
      tok_is_match <= ld_is_match_s;
      tok_literal  <= ld_literal_s;
      tok_offset   <= ld_offset_s;
      tok_length   <= ld_length_s;
      tok_last     <= ld_last_s;
    end else if (tok_ready) begin
      tok_valid    <= 1'b0;
      tok_is_match <= 1'b0;
      tok_literal  <= 8'h00;
      tok_offset   <= {OFF_W{1'b0}};
      tok_length   <= {LEN_W{1'b0}};
      tok_last     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lz_token_encoder.sv
// Bench for lz_token_encoder: blocks of symbols are turned into expected
// tokens by a run-grouping model, and a monitor compares every token the
// packer side accepts, plus field stability under backpressure.
module tb_lz_token_encoder;

  localparam int OFF_W     = 8;
  localparam int LEN_W     = 4;
  localparam int MIN_MATCH = 3;
  localparam int MAX_LEN   = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_byte = 8'h00;
  logic             in_hit = 1'b0;
  logic [OFF_W-1:0] in_offset = '0;
  logic             in_last = 1'b0;
  logic             tok_valid;
  logic             tok_ready = 1'b1;
  logic             tok_is_match;
  logic [7:0]       tok_literal;
  logic [OFF_W-1:0] tok_offset;
  logic [LEN_W-1:0] tok_length;
  logic             tok_last;

  typedef struct packed {
    logic             m;
    logic [7:0]       lit;
    logic [OFF_W-1:0] off;
    logic [LEN_W-1:0] len;
    logic             last;
  } tok_t;

  typedef struct packed {
    logic [7:0]       b;
    logic             hit;
    logic [OFF_W-1:0] off;
  } sym_t;

  sym_t blk_q[$];
  tok_t res_q[$];
  tok_t exp_q[$];
  tok_t pin_q[$];
  int   xfer_cyc_q[$];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int gap_pct = 0;
  int first_acc_cyc = 0;

  lz_token_encoder #(
    .OFF_W(OFF_W), .LEN_W(LEN_W), .MIN_MATCH(MIN_MATCH), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .in_hit(in_hit), .in_offset(in_offset), .in_last(in_last),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_match(tok_is_match), .tok_literal(tok_literal),
    .tok_offset(tok_offset), .tok_length(tok_length), .tok_last(tok_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic tok_t mk_lit(logic [7:0] b, logic last);
    tok_t t;
    t = '0;
    t.lit = b;
    t.last = last;
    return t;
  endfunction

  function automatic tok_t mk_match(logic [OFF_W-1:0] off, int len, logic last);
    tok_t t;
    t = '0;
    t.m = 1'b1;
    t.off = off;
    t.len = LEN_W'(len);
    t.last = last;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_sym(logic [7:0] b, logic hit, logic [OFF_W-1:0] off);
    sym_t s;
    s.b = b;
    s.hit = hit;
    s.off = off;
    blk_q.push_back(s);
  endtask

  // Reference: greedy runs of same-offset hits, capped at MAX_LEN; short
  // runs and misses become literals; the last token of the block is flagged.
  task automatic model_block();
    int i;
    int j;
    int n;
    tok_t t;
    res_q.delete();
    n = blk_q.size();
    i = 0;
    while (i < n) begin
      if (!blk_q[i].hit) begin
        res_q.push_back(mk_lit(blk_q[i].b, 1'b0));
        i++;
      end else begin
        j = i;
        while (j < n && blk_q[j].hit && blk_q[j].off == blk_q[i].off && (j - i) < MAX_LEN)
          j++;
        if ((j - i) >= MIN_MATCH)
          res_q.push_back(mk_match(blk_q[i].off, j - i, 1'b0));
        else
          for (int k = i; k < j; k++) res_q.push_back(mk_lit(blk_q[k].b, 1'b0));
        i = j;
      end
    end
    if (res_q.size() > 0) begin
      t = res_q.pop_back();
      t.last = 1'b1;
      res_q.push_back(t);
    end
  endtask

  task automatic pin_check(string name);
    model_block();
    check({name, "_count"}, 32'(res_q.size()), 32'(pin_q.size()));
    for (int i = 0; i < pin_q.size() && i < res_q.size(); i++)
      check({name, "_tok"}, 32'(res_q[i]), 32'(pin_q[i]));
    pin_q.delete();
  endtask

  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic send_sym(logic [7:0] b, logic hit, logic [OFF_W-1:0] off,
                          logic last, output int acc_cyc);
    logic ok;
    int waited;
    ok = 1'b0;
    waited = 0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_byte = b;
    in_hit = hit;
    in_offset = off;
    in_last = last;
    while (!ok && waited < 200) begin
      #4;
      ok = in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (!ok) begin
      n_vec++;
      n_mis++;
      $display("FAIL accept_timeout: in_ready stayed %0d, required 1", ok);
    end
    in_valid = 1'b0;
    in_hit = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_block();
    int acc;
    int n;
    model_block();
    foreach (res_q[i]) exp_q.push_back(res_q[i]);
    n = blk_q.size();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gap_pct) @(negedge clk);
      send_sym(blk_q[i].b, blk_q[i].hit, blk_q[i].off, (i == n - 1), acc);
      if (i == 0) first_acc_cyc = acc;
    end
    blk_q.delete();
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || tok_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  // Packer-side ready pattern.
  always @(negedge clk) begin
    case (rdy_mode)
      0: tok_ready = 1'b1;
      1: tok_ready = ~tok_ready;
      default: tok_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: every accepted token against the model, and field
  // stability whenever the previous cycle was stalled.
  tok_t prev_tok;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    tok_t cur;
    tok_t e;
    #4;
    cur = tok_t'({tok_is_match, tok_literal, tok_offset, tok_length, tok_last});
    if (!reset) begin
      if (prev_stall)
        check("hold_stable", 32'({tok_valid, cur}), 32'({1'b1, prev_tok}));
      if (tok_valid && tok_ready) begin
        xfer_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_token", 32'(cur), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("token", 32'(cur), 32'(e));
        end
      end
      prev_stall = tok_valid && !tok_ready;
      prev_tok = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int n;
    int miss_pct;
    logic [OFF_W-1:0] off;

    // Reset state.
    @(negedge clk);
    #4;
    check("reset_tok", 32'({tok_valid, tok_is_match, tok_literal, tok_offset, tok_length, tok_last}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Literals only, back to back, with one-cycle latency.
    rdy_mode = 0;
    gap_pct = 0;
    push_sym(8'h41, 1'b0, 8'h00);
    push_sym(8'h42, 1'b0, 8'h00);
    push_sym(8'h43, 1'b0, 8'h00);
    pin_q.push_back(mk_lit(8'h41, 1'b0));
    pin_q.push_back(mk_lit(8'h42, 1'b0));
    pin_q.push_back(mk_lit(8'h43, 1'b1));
    pin_check("pin_literals");
    xfer_cyc_q.delete();
    run_block();
    drain();
    check("lit_xfer_count", 32'(xfer_cyc_q.size()), 32'd3);
    check("lit_latency", 32'(xfer_cyc_q[0] - first_acc_cyc), 32'd1);
    check("lit_b2b_1", 32'(xfer_cyc_q[1] - xfer_cyc_q[0]), 32'd1);
    check("lit_b2b_2", 32'(xfer_cyc_q[2] - xfer_cyc_q[1]), 32'd1);

    // Five-hit match followed by a closing literal.
    for (int i = 0; i < 5; i++) push_sym(8'(8'h60 + i), 1'b1, 8'h10);
    push_sym(8'h7A, 1'b0, 8'h00);
    pin_q.push_back(mk_match(8'h10, 5, 1'b0));
    pin_q.push_back(mk_lit(8'h7A, 1'b1));
    pin_check("pin_match");
    run_block();
    drain();

    // Short run replayed as literals.
    push_sym(8'h11, 1'b1, 8'h04);
    push_sym(8'h22, 1'b1, 8'h04);
    push_sym(8'h33, 1'b0, 8'h00);
    pin_q.push_back(mk_lit(8'h11, 1'b0));
    pin_q.push_back(mk_lit(8'h22, 1'b0));
    pin_q.push_back(mk_lit(8'h33, 1'b1));
    pin_check("pin_short");
    run_block();
    drain();

    // Offset change between two minimum-length matches.
    for (int i = 0; i < 3; i++) push_sym(8'(8'hA0 + i), 1'b1, 8'h08);
    for (int i = 0; i < 3; i++) push_sym(8'(8'hB0 + i), 1'b1, 8'h09);
    pin_q.push_back(mk_match(8'h08, 3, 1'b0));
    pin_q.push_back(mk_match(8'h09, 3, 1'b1));
    pin_check("pin_offchg");
    run_block();
    drain();

    // Maximum length with toggling backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 17; i++) push_sym(8'(8'hC0 + i), 1'b1, 8'h02);
    pin_q.push_back(mk_match(8'h02, 15, 1'b0));
    pin_q.push_back(mk_lit(8'hCF, 1'b0));
    pin_q.push_back(mk_lit(8'hD0, 1'b1));
    pin_check("pin_maxlen");
    run_block();
    drain();

    // Reset in the middle of a run drops the candidate.
    rdy_mode = 0;
    @(negedge clk);
    send_sym(8'h01, 1'b1, 8'h04, 1'b0, acc);
    send_sym(8'h02, 1'b1, 8'h04, 1'b0, acc);
    reset = 1'b1;
    #4;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #4;
    check("postrst_tok_valid", 32'(tok_valid), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    push_sym(8'h55, 1'b0, 8'h00);
    pin_q.push_back(mk_lit(8'h55, 1'b1));
    pin_check("pin_after_reset");
    run_block();
    drain();

    // Randomized blocks against the model.
    for (int bl = 0; bl < 60; bl++) begin
      rdy_mode = $urandom_range(0, 2);
      gap_pct = $urandom_range(0, 30);
      miss_pct = $urandom_range(0, 40);
      n = $urandom_range(1, 40);
      off = OFF_W'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 99) < 15) off = OFF_W'($urandom_range(1, 3));
        push_sym(8'($urandom_range(0, 255)), ($urandom_range(0, 99) >= miss_pct), off);
      end
      run_block();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
